// File: rtl/ifmap_stream_loader.sv
// Streams LEN consecutive memory words, starting at a latched base address, through a
// small credit-controlled FIFO to a valid/ready consumer, then emits a one-cycle done pulse.
module ifmap_stream_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int LEN    = 76
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [ADDR_W-1:0]        i_base_adr,
   output logic                     o_mem_rd,
   output logic [ADDR_W-1:0]        o_mem_adr,
   input  logic [DATA_W-1:0]        i_mem_rdata,
   output logic [DATA_W-1:0]        o_out_data,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [1:0]               o_dbg_state,
   output logic [$clog2(DEPTH):0]   o_dbg_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [CNT_W-1:0]    r_issued, r_returned, r_popped;
   logic                r_inflight;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]      r_count;

   logic                w_mem_rd, w_start_acc, w_push, w_pop, w_credit;
   logic [PTR_W+1:0]    w_occupancy;
   logic [CNT_W-1:0]    w_popped_nxt;
   logic [ADDR_W-1:0]   w_adr;

   // Stream handshake: a word transfers on a rising edge where o_out_valid and i_out_ready are both 1;
   // o_out_data is held stable while o_out_valid=1 and no transfer has occurred.
   assign w_push       = r_inflight;
   assign w_pop        = o_out_valid & i_out_ready;
   assign w_occupancy  = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
   assign w_credit     = w_occupancy < (PTR_W+2)'(DEPTH);
   assign w_popped_nxt = r_popped + (w_pop ? CNT_W'(1) : '0);
   assign w_adr        = r_base + ADDR_W'(r_issued);

   always_comb begin
      w_state_nxt = r_state;
      w_mem_rd    = 1'b0;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_mem_rd = (r_issued < LEN_C) && w_credit;
            if (w_mem_rd && (r_issued == LEN_C - CNT_W'(1))) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave as the last word pops so done lands LEN+2 cycles after start when unthrottled.
            if ((r_returned == LEN_C) && (w_popped_nxt == LEN_C)) w_state_nxt = S_DONE;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_popped   <= '0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_mem_rd;
         if (w_start_acc) begin
            r_base     <= i_base_adr;
            r_issued   <= '0;
            r_returned <= '0;
            r_popped   <= '0;
         end else begin
            if (w_mem_rd) r_issued   <= r_issued + CNT_W'(1);
            if (w_push)   r_returned <= r_returned + CNT_W'(1);
            if (w_pop)    r_popped   <= r_popped + CNT_W'(1);
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_mem_rdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   assign o_mem_rd    = w_mem_rd;
   assign o_mem_adr   = w_mem_rd ? w_adr : '0;
   assign o_out_data  = r_mem[r_rd_ptr];
   assign o_out_valid = (r_count != '0);
   assign o_busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign o_done      = (r_state == S_DONE);
   assign o_dbg_state = r_state;
   assign o_dbg_count = r_count;
endmodule

// File: tb/tb_ifmap_stream_loader.sv
// Randomized bench for ifmap_stream_loader: a memory responder, an expected-word and
// expected-address scoreboard filled at start, and a negedge monitor that pops and compares.
module tb_ifmap_stream_loader;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int LEN    = 76;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b1;
   logic                i_start = 1'b0;
   logic [ADDR_W-1:0]   i_base_adr = '0;
   logic                o_mem_rd;
   logic [ADDR_W-1:0]   o_mem_adr;
   logic [DATA_W-1:0]   i_mem_rdata = '0;
   logic [DATA_W-1:0]   o_out_data;
   logic                o_out_valid;
   logic                i_out_ready = 1'b1;
   logic                o_busy;
   logic                o_done;
   logic [1:0]          o_dbg_state;
   logic [$clog2(DEPTH):0] o_dbg_count;

   ifmap_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN(LEN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_adr(i_base_adr),
      .o_mem_rd(o_mem_rd), .o_mem_adr(o_mem_adr), .i_mem_rdata(i_mem_rdata),
      .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
   );

   always #5 i_clk = ~i_clk;

   logic [DATA_W-1:0] mem [256];
   logic [DATA_W-1:0] exp_q [$];
   logic [ADDR_W-1:0] adr_q [$];
   int total = 0;
   int bad = 0;
   int rd_total = 0;
   int n_pop = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous memory: data for a read strobe is presented in the following cycle.
   always @(posedge i_clk) if (o_mem_rd) i_mem_rdata <= mem[o_mem_adr];

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_mem_rd) begin
            rd_total++;
            if (adr_q.size() == 0) chk("unexpected_read", 1, 0);
            else chk("mem_adr", int'(o_mem_adr), int'(adr_q.pop_front()));
            chk("credit_bound", int'(rd_total - n_pop <= DEPTH), 1);
         end
         if (o_out_valid && i_out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
            else chk("out_data", int'(o_out_data), int'(exp_q.pop_front()));
         end
         if (o_dbg_count > DEPTH) chk("fifo_overflow", int'(o_dbg_count), DEPTH);
      end
   end

   // mode: 0 ready high, 1 stall cycles 3..20, 2 random ready, 3 extra starts; rst_at>0 aborts.
   task automatic run_txn(input logic [ADDR_W-1:0] base, input int mode, input int rst_at);
      int c;
      int dones;
      logic [DATA_W-1:0] held;
      for (int i = 0; i < LEN; i++) begin
         adr_q.push_back(ADDR_W'(int'(base) + i));
         exp_q.push_back(mem[ADDR_W'(int'(base) + i)]);
      end
      rd_total = 0;
      n_pop = 0;
      dones = 0;
      held = '0;
      i_base_adr = base;
      i_start = 1'b1;
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_base_adr = ~base;
      c = 0;
      chk("busy_after_start", int'(o_busy), 1);
      while (c < 3000) begin
         if (rst_at > 0 && c == rst_at) begin
            chk("rst_mem_rd", int'(o_mem_rd), 0);
            chk("rst_out_valid", int'(o_out_valid), 0);
            chk("rst_busy", int'(o_busy), 0);
            i_rst = 1'b0;
            exp_q.delete();
            adr_q.delete();
            for (int k = 0; k < 6; k++) begin
               @(posedge i_clk); #1;
               chk("rst_no_done", int'(o_done), 0);
               chk("rst_dropped", int'(o_out_valid), 0);
            end
            return;
         end
         if (o_done) begin
            dones++;
            if (mode == 0 || mode == 3) chk("done_latency", c, LEN + 2);
            chk("busy_in_done", int'(o_busy), 0);
            break;
         end
         if (mode == 1) begin
            if (c == 4) held = o_out_data;
            if (c >= 10 && c <= 20) begin
               chk("stall_mem_rd", int'(o_mem_rd), 0);
               chk("stall_valid", int'(o_out_valid), 1);
               chk("stall_hold", int'(o_out_data), int'(held));
            end
            i_out_ready = !(c >= 3 && c <= 20);
         end else if (mode == 2) begin
            i_out_ready = 1'($urandom_range(0, 1));
         end else if (mode == 3) begin
            i_start = (c == 5) || (c == LEN + 1);
            if (c == LEN + 1) chk("busy_drain", int'(o_busy), 1);
         end
         if (rst_at > 0 && c == rst_at - 1) i_rst = 1'b1;
         @(posedge i_clk); #1;
         c++;
      end
      if (c >= 3000) chk("done_timeout", c, LEN + 2);
      i_start = 1'b0;
      i_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk); #1;
         if (o_done) dones++;
         chk("idle_busy", int'(o_busy), 0);
      end
      chk("done_count", dones, 1);
      chk("words_left", exp_q.size(), 0);
      chk("addrs_left", adr_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_mem_rd", int'(o_mem_rd), 0);
      chk("reset_mem_adr", int'(o_mem_adr), 0);
      chk("reset_valid", int'(o_out_valid), 0);
      chk("reset_data", int'(o_out_data), 0);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_done", int'(o_done), 0);
      chk("reset_count", int'(o_dbg_count), 0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      run_txn(8'h10, 0, 0);
      run_txn(8'h10, 1, 0);
      run_txn(8'hF0, 0, 0);
      run_txn(8'h10, 0, 10);
      run_txn(8'h00, 0, 0);
      run_txn(8'h10, 3, 0);
      for (int t = 0; t < 10; t++) run_txn(ADDR_W'($urandom_range(0, 255)), 2, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
